// File: rtl/turn_sequencer_if.sv
// Move-request / board-bank bus between the player input logic, the position
// register bank and the turn sequencer.
interface turn_sequencer_if;
   logic        play;
   logic [3:0]  player_pos;
   logic [31:0] board;
   logic [15:0] PL_en;
   logic [15:0] PC_en;
   logic        illegal_move;
   logic        ready;
   logic        game_over;
   logic [1:0]  winner;
   logic        draw;

   modport master (
      output play, player_pos, board,
      input  PL_en, PC_en, illegal_move, ready, game_over, winner, draw
   );

   modport slave (
      input  play, player_pos, board,
      output PL_en, PC_en, illegal_move, ready, game_over, winner, draw
   );
endinterface

// File: rtl/turn_sequencer.sv
// 4x4 tic-tac-toe game-flow controller: validates player moves, issues the
// computer's lowest-empty-cell reply and detects wins and draws.
module turn_sequencer (
   input  logic           clock,
   input  logic           reset,
   turn_sequencer_if.slave bus
);
   localparam int unsigned N_CELLS = 16;
   localparam int unsigned CELL_W  = 2;

   typedef enum logic [2:0] {
      S_IDLE, S_PL_WR, S_PL_CHK, S_PC_WR, S_PC_CHK, S_OVER
   } state_t;

   state_t               r_state, w_state_nxt;
   logic [N_CELLS-1:0]   r_pl_en, w_pl_en_nxt;
   logic [N_CELLS-1:0]   r_pc_en, w_pc_en_nxt;
   logic                 r_illegal, w_illegal_nxt;
   logic                 r_ready, w_ready_nxt;
   logic                 r_game_over, w_game_over_nxt;
   logic [CELL_W-1:0]    r_winner, w_winner_nxt;
   logic                 r_draw, w_draw_nxt;

   logic [N_CELLS-1:0]   w_pl_cells, w_pc_cells, w_empty, w_low_empty;
   logic                 w_full, w_pl_line, w_pc_line;

   // True when the marked cells cover any row, column or diagonal.
   function automatic logic has_line(input logic [N_CELLS-1:0] cells);
      logic hit;
      hit = 1'b0;
      for (int r = 0; r < 4; r++) begin
         hit = hit | (&cells[4*r +: 4]);
         hit = hit | (cells[r] & cells[r+4] & cells[r+8] & cells[r+12]);
      end
      hit = hit | (cells[0] & cells[5] & cells[10] & cells[15]);
      hit = hit | (cells[3] & cells[6] & cells[9]  & cells[12]);
      return hit;
   endfunction

   // Per-cell decode; code 11 is occupied but owned by neither side.
   always_comb begin
      w_pl_cells  = '0;
      w_pc_cells  = '0;
      w_empty     = '0;
      w_low_empty = '0;
      for (int i = 0; i < 16; i++) begin
         w_pl_cells[i] = (bus.board[2*i +: 2] == 2'b01);
         w_pc_cells[i] = (bus.board[2*i +: 2] == 2'b10);
         w_empty[i]    = (bus.board[2*i +: 2] == 2'b00);
      end
      for (int i = 15; i >= 0; i--) begin
         if (w_empty[i]) w_low_empty = N_CELLS'(1) << i;
      end
   end

   assign w_full    = (w_empty == '0);
   assign w_pl_line = has_line(w_pl_cells);
   assign w_pc_line = has_line(w_pc_cells);

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         r_state     <= S_IDLE;
         r_pl_en     <= '0;
         r_pc_en     <= '0;
         r_illegal   <= 1'b0;
         r_ready     <= 1'b1;
         r_game_over <= 1'b0;
         r_winner    <= 2'b00;
         r_draw      <= 1'b0;
      end else begin
         r_state     <= w_state_nxt;
         r_pl_en     <= w_pl_en_nxt;
         r_pc_en     <= w_pc_en_nxt;
         r_illegal   <= w_illegal_nxt;
         r_ready     <= w_ready_nxt;
         r_game_over <= w_game_over_nxt;
         r_winner    <= w_winner_nxt;
         r_draw      <= w_draw_nxt;
      end
   end

   // Next state and next registered outputs; enables and illegal are pulses.
   always_comb begin
      w_state_nxt   = r_state;
      w_pl_en_nxt   = '0;
      w_pc_en_nxt   = '0;
      w_illegal_nxt = 1'b0;
      w_winner_nxt  = r_winner;
      w_draw_nxt    = r_draw;
      case (r_state)
         S_IDLE: begin
            if (bus.play) begin
               if (w_empty[bus.player_pos]) begin
                  w_pl_en_nxt = N_CELLS'(1) << bus.player_pos;
                  w_state_nxt = S_PL_WR;
               end else begin
                  w_illegal_nxt = 1'b1;
               end
            end
         end
         S_PL_WR: w_state_nxt = S_PL_CHK;
         S_PL_CHK: begin
            if (w_pl_line) begin
               w_winner_nxt = 2'b01;
               w_state_nxt  = S_OVER;
            end else if (w_full) begin
               w_draw_nxt  = 1'b1;
               w_state_nxt = S_OVER;
            end else begin
               w_pc_en_nxt = w_low_empty;
               w_state_nxt = S_PC_WR;
            end
         end
         S_PC_WR: w_state_nxt = S_PC_CHK;
         S_PC_CHK: begin
            if (w_pc_line) begin
               w_winner_nxt = 2'b10;
               w_state_nxt  = S_OVER;
            end else if (w_full) begin
               w_draw_nxt  = 1'b1;
               w_state_nxt = S_OVER;
            end else begin
               w_state_nxt = S_IDLE;
            end
         end
         S_OVER: w_illegal_nxt = bus.play;
         default: w_state_nxt = S_IDLE;
      endcase
      w_ready_nxt     = (w_state_nxt == S_IDLE);
      w_game_over_nxt = (w_state_nxt == S_OVER);
   end

   assign bus.PL_en        = r_pl_en;
   assign bus.PC_en        = r_pc_en;
   assign bus.illegal_move = r_illegal;
   assign bus.ready        = r_ready;
   assign bus.game_over    = r_game_over;
   assign bus.winner       = r_winner;
   assign bus.draw         = r_draw;
endmodule

// File: doc/turn_sequencer.md
# turn_sequencer

Game-flow controller for the 4x4 tic-tac-toe board. It accepts player move requests, checks them against the current board, and drives the per-cell write enables and the illegal-move flag of the 16-cell position register bank. After each legal player move it generates the computer's reply and detects four-in-a-row wins and a full-board draw. It sits between the player input logic and the position register bank, and reads back that bank's contents every cycle.

## Interface
- No parameters. Board size is fixed at 4x4, 16 cells.
- clock  in  1  game clock; all state changes on the rising edge.
- reset  in  1  asynchronous, active-low; returns the FSM and all outputs to their reset values.
- play  in  1  move request; sampled only in IDLE.
- player_pos  in  4  cell index 0..15 for the requested move; row-major, cell i = row i/4, column i%4.
- board  in  32  current board; cell i = board[2i+1:2i], where 00 = empty, 01 = player, 10 = computer.
- PL_en  out  16  one-hot player write enable, one-cycle pulse.
- PC_en  out  16  one-hot computer write enable, one-cycle pulse.
- illegal_move  out  1  registered one-cycle pulse flagging a rejected request.
- ready  out  1  high only in IDLE.
- game_over  out  1  high only in OVER.
- winner  out  2  00 = none or draw, 01 = player, 10 = computer.
- draw  out  1  board full with no winner.

## Operation
- States:
  - IDLE: waiting for a request.
  - PL_WR: player enable pulse is on the bus.
  - PL_CHK: evaluate the board after the player write.
  - PC_WR: computer enable pulse is on the bus.
  - PC_CHK: evaluate the board after the computer write.
  - OVER: game finished.
- All outputs are registered. Reset values: state = IDLE, PL_en = 0, PC_en = 0, illegal_move = 0, game_over = 0, winner = 00, draw = 0. ready = 1 once reset is released.
- IDLE, play = 1, and board cell player_pos is empty: load PL_en = 1<<player_pos and go to PL_WR.
- IDLE, play = 1, and the cell is occupied: illegal_move = 1 for one cycle, PL_en stays 0, remain in IDLE.
- PL_WR: clear PL_en and go to PL_CHK.
- PL_CHK, in priority order:
  - player holds a line: winner = 01, go to OVER.
  - no empty cell: draw = 1, go to OVER.
  - otherwise: PC_en = one-hot of the lowest-index empty cell, go to PC_WR.
- PC_WR: clear PC_en and go to PC_CHK.
- PC_CHK, in priority order:
  - computer holds a line: winner = 10, go to OVER.
  - board full: draw = 1, go to OVER.
  - otherwise: go to IDLE.
- A line is one of 10 lines: 4 rows, 4 columns, main diagonal (0, 5, 10, 15), anti-diagonal (3, 6, 9, 12). A side holds a line when all 4 of its cells carry that side's code.
- OVER: play = 1 gives an illegal_move pulse. The state is held until reset.
- play in any state other than IDLE and OVER is ignored: no pulse and no queuing.
- illegal_move and an enable are never high in the same cycle. PL_en and PC_en are never both nonzero.
- Board codes 11 count as occupied and belong to neither side.

## Timing
- The request is sampled at edge k.
- PL_en is high from edge k to edge k+1. The board reflects the player write after edge k+1.
- PL_CHK decides at edge k+2. PC_en is high from edge k+2 to edge k+3.
- PC_CHK decides at edge k+4. ready returns after edge k+4, so a new request is accepted at edge k+5 at the earliest.
- On a player win or draw, OVER is entered at edge k+2 and PC_en never pulses.
- illegal_move is high for exactly the cycle after edge k.
- Reset asserted in any state (including PL_WR and PC_WR): all outputs are forced to their reset values immediately, without waiting for a clock edge. A partially issued enable pulse is truncated.
- Win and full-board checks are combinational on the board input and are used only in the CHK states.

## Test plan
- Reset, empty board, play with player_pos = 5 at edge k:
  - PL_en = 0x0020 for one cycle.
  - PC_en = 0x0001 for one cycle starting at edge k+2.
  - ready = 1 after edge k+4, winner = 00.
- Cell 7 already = 01, play with player_pos = 7: illegal_move pulses one cycle, PL_en = PC_en = 0, state stays IDLE.
- Player plays 4, 5, 6, 7 while the bench board model echoes the writes: computer replies 0, 1, 2; after the 4th move winner = 01 and game_over = 1 at edge k+2, with no PC_en.
- Player plays 15, 14, 13, 8: computer replies 0, 1, 2, 3; winner = 10 and game_over = 1 after edge k+4 of the 4th move.
- Bench board has 15 cells filled with no line and cell 12 empty; play with player_pos = 12 completes no line: draw = 1, winner = 00, no PC_en. A following play gives an illegal_move pulse.
- Reset asserted while PC_en = 0x0001 is high: PC_en drops to 0 immediately and all outputs take their reset values. After release, ready = 1 and the FSM accepts a new move.
